dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory slave: latches one load/store request, waits a fixed
// number of cycles, performs the access, then holds the response until taken.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic        err;
    logic        do_write;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign err = (size_q == 2'b11)
               | ((size_q == 2'b01) & addr_q[0])
               | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
               | ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = (size_q == 2'b10)
                               | ((size_q == 2'b01) & (addr_q[1] == 1'(gi / 2)))
                               | ((size_q == 2'b00) & (addr_q[1:0] == 2'(gi)));
            assign lane_wdata[gi*8 +: 8] = (size_q == 2'b10) ? wdata_q[gi*8 +: 8] :
                                           (size_q == 2'b01) ? wdata_q[(gi%2)*8 +: 8] :
                                                               wdata_q[7:0];
        end
    endgenerate

    // Read is registered: in IDLE the incoming address is used so the word is
    // ready by ACCESS even when there are no wait states.
    assign rd_idx   = (state_q == S_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    assign wr_idx   = addr_q[AW+1:2];
    assign do_write = (state_q == S_ACCESS) & we_q & ~err & ~reset;

    always_ff @(posedge clk) begin
        rd_word_q <= mem[rd_idx];
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) mem[wr_idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
            end
        end
    end

    assign byte_sel = rd_word_q[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = rd_word_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err;
                rsp_rdata_d = (err | we_q) ? 32'd0 : load_data;
            end
            default: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule
